// File: rtl/flappy_pkg.sv
// flappy_pkg: shared constants and types for the flappy-bird datapath.
//   - FSM state encodings for the bird motion engine
//   - screen limits (FLOOR_Y, CEIL_Y, START_Y) in pixels, 0 = top
//   - physics defaults (FLAP_VEL, GRAVITY, MAX_FALL) in px/frame
//   - widths Y_W (unsigned Y) and V_W (signed velocity)
//   - sign/zero-extension helpers for the wide physics arithmetic
package flappy_pkg;

    localparam int unsigned Y_W  = 10;
    localparam int unsigned V_W  = 6;
    // Y arithmetic is done signed with two extra bits so y + v can go
    // below zero or above the Y range without wrapping.
    localparam int unsigned YS_W = Y_W + 2;

    localparam logic [Y_W-1:0] START_Y = 10'd240;
    localparam logic [Y_W-1:0] FLOOR_Y = 10'd440;
    localparam logic [Y_W-1:0] CEIL_Y  = 10'd0;

    localparam logic signed [V_W-1:0] FLAP_VEL = -6'sd8;
    localparam logic signed [V_W-1:0] GRAVITY  = 6'sd1;
    localparam logic signed [V_W-1:0] MAX_FALL = 6'sd10;

    typedef enum logic [1:0] {
        StWait = 2'd0,
        StFly  = 2'd1,
        StDead = 2'd2
    } bird_state_e;

    // Velocity widened by one bit so v + GRAVITY cannot overflow before saturation.
    function automatic logic signed [V_W:0] widen_v(input logic signed [V_W-1:0] v);
        return {v[V_W-1], v};
    endfunction

    // Unsigned Y zero-extended into the signed physics width.
    function automatic logic signed [YS_W-1:0] widen_y(input logic [Y_W-1:0] y);
        return {{(YS_W-Y_W){1'b0}}, y};
    endfunction

    // Signed velocity sign-extended into the signed physics width.
    function automatic logic signed [YS_W-1:0] v_to_y(input logic signed [V_W-1:0] v);
        return {{(YS_W-V_W){v[V_W-1]}}, v};
    endfunction

endpackage

// File: rtl/bird_motion_if.sv
// bird_motion_if: signal bundle between the keyboard/frame/collision side and
// the bird motion engine.
//   spacebar_pressed  key level from the PS/2 receiver
//   frame_tick        one-cycle pulse per video frame
//   game_over         collision level from the pipe logic
//   bird_y            current Y (registered)
//   bird_vel          current signed velocity (registered)
//   state             engine FSM state (WAIT/FLY/DEAD)
//   died              one-cycle pulse on entry to DEAD
// Modports: master drives the inputs and observes the outputs; slave is the engine.
interface bird_motion_if
    import flappy_pkg::*;
();
    logic                  spacebar_pressed;
    logic                  frame_tick;
    logic                  game_over;
    logic [Y_W-1:0]        bird_y;
    logic signed [V_W-1:0] bird_vel;
    logic [1:0]            state;
    logic                  died;

    modport master (
        output spacebar_pressed,
        output frame_tick,
        output game_over,
        input  bird_y,
        input  bird_vel,
        input  state,
        input  died
    );

    modport slave (
        input  spacebar_pressed,
        input  frame_tick,
        input  game_over,
        output bird_y,
        output bird_vel,
        output state,
        output died
    );
endinterface

// File: rtl/rise_detect.sv
// rise_detect: registers a same-clock-domain level and emits a one-cycle pulse
// on each 0->1 transition. A held level produces exactly one pulse.
//   clk    system clock
//   reset  asynchronous active-high reset (previous level cleared to 0)
//   level  input level
//   pulse  combinational rising-edge pulse (level & ~previous level)
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse = level & ~prev_q;

endmodule

// File: rtl/bird_motion.sv
// bird_motion: vertical-motion engine for the bird. Turns each new spacebar
// press into one flap impulse and integrates gravity/velocity once per frame.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    bird_motion_if.slave:
//            in : spacebar_pressed, frame_tick, game_over
//            out: bird_y, bird_vel, state, died (all registered)
module bird_motion
    import flappy_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    bird_motion_if.slave bus
);

    bird_state_e           state_q, state_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] v_q, v_d;
    logic                  pend_q, pend_d;
    logic                  died_q, died_d;

    logic                  press;
    logic                  flap;
    logic signed [V_W:0]   v_grav;
    logic signed [V_W-1:0] v_new;
    logic signed [YS_W-1:0] y_sum;
    logic [Y_W-1:0]        phys_y;
    logic signed [V_W-1:0] phys_v;
    logic                  phys_floor;

    rise_detect u_space (
        .clk   (clk),
        .reset (reset),
        .level (bus.spacebar_pressed),
        .pulse (press)
    );

    // One frame of physics from the current Y/velocity; only committed on frame_tick.
    always_comb begin : physics
        flap   = pend_q | press;
        v_grav = widen_v(v_q) + widen_v(GRAVITY);
        if (flap) begin
            v_new = FLAP_VEL;
        end else if (v_grav > widen_v(MAX_FALL)) begin
            v_new = MAX_FALL;
        end else begin
            v_new = v_grav[V_W-1:0];
        end

        y_sum      = widen_y(y_q) + v_to_y(v_new);
        phys_y     = y_sum[Y_W-1:0];
        phys_v     = v_new;
        phys_floor = 1'b0;
        if (y_sum <= widen_y(CEIL_Y)) begin
            // Hitting the ceiling is not fatal: pin to the top and stop.
            phys_y = CEIL_Y;
            phys_v = '0;
        end else if (y_sum >= widen_y(FLOOR_Y)) begin
            phys_y     = FLOOR_Y;
            phys_v     = '0;
            phys_floor = 1'b1;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        y_d     = y_q;
        v_d     = v_q;
        pend_d  = pend_q;

        unique case (state_q)
            StWait: begin
                y_d    = START_Y;
                v_d    = '0;
                pend_d = 1'b0;
                if (press) begin
                    state_d = StFly;
                    if (bus.frame_tick) begin
                        // Press and tick on the same edge: flap lands immediately.
                        y_d = phys_y;
                        v_d = phys_v;
                        if (phys_floor) begin
                            state_d = StDead;
                        end
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end

            StFly: begin
                // Any tick consumes the pending flap; a same-edge press is used by that tick.
                pend_d = bus.frame_tick ? 1'b0 : (pend_q | press);
                if (bus.game_over) begin
                    // Collision wins over a coincident tick: freeze where we are.
                    state_d = StDead;
                    pend_d  = 1'b0;
                end else if (bus.frame_tick) begin
                    y_d = phys_y;
                    v_d = phys_v;
                    if (phys_floor) begin
                        state_d = StDead;
                    end
                end
            end

            StDead: begin
                pend_d = 1'b0;
                if (press && !bus.game_over) begin
                    state_d = StWait;
                    y_d     = START_Y;
                    v_d     = '0;
                end
            end

            default: begin
                state_d = StWait;
                y_d     = START_Y;
                v_d     = '0;
                pend_d  = 1'b0;
            end
        endcase

        // Single pulse per DEAD entry regardless of which cause(s) triggered it.
        died_d = (state_d == StDead) && (state_q != StDead);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWait;
            y_q     <= START_Y;
            v_q     <= '0;
            pend_q  <= 1'b0;
            died_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            v_q     <= v_d;
            pend_q  <= pend_d;
            died_q  <= died_d;
        end
    end

    assign bus.bird_y   = y_q;
    assign bus.bird_vel = v_q;
    assign bus.state    = state_q;
    assign bus.died     = died_q;

endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: directed stimulus with a scoreboard queue. Stimulus pushes
// expected outputs; a monitor on the falling edge pops and compares them.
module tb_bird_motion;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bird_motion_if bif ();

    bird_motion dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        string name;
        int    y;
        int    v;
        int    st;
        int    died;
        int    dcnt;
    } exp_t;

    exp_t sb[$];
    int   total      = 0;
    int   bad        = 0;
    int   died_seen  = 0;
    int   dcnt_exp   = 0;
    int   my;
    int   mv;
    bit   mfloor;

    // Monitor: count died pulses, then check every queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   ay, av, ast, ad;
        if (bif.died === 1'b1) died_seen++;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            ay  = int'(bif.bird_y);
            av  = int'(bif.bird_vel);
            ast = int'(bif.state);
            ad  = int'(bif.died);
            total++;
            if ($isunknown({bif.bird_y, bif.bird_vel, bif.state, bif.died}) ||
                ay != e.y || av != e.v || ast != e.st || ad != e.died ||
                died_seen != e.dcnt) begin
                bad++;
                $display("FAIL %s: got y=%0d v=%0d st=%0d died=%0d pulses=%0d, want y=%0d v=%0d st=%0d died=%0d pulses=%0d",
                         e.name, ay, av, ast, ad, died_seen, e.y, e.v, e.st, e.died, e.dcnt);
            end
        end
    end

    task automatic expect_out(input string n, input int y, input int v, input int st,
                              input int d);
        exp_t e;
        e.name = n;
        e.y    = y;
        e.v    = v;
        e.st   = st;
        e.died = d;
        e.dcnt = dcnt_exp;
        sb.push_back(e);
    endtask

    task automatic step(input logic sp, input logic ft, input logic go);
        bif.spacebar_pressed = sp;
        bif.frame_tick       = ft;
        bif.game_over        = go;
        @(posedge clk);
        #1;
        bif.frame_tick = 1'b0;
    endtask

    // Reference physics written independently from the RTL, in plain integers.
    task automatic model_tick(inout int y, inout int v, input bit fl, output bit floor_hit);
        int nv, ny;
        nv = fl ? -8 : ((v + 1 > 10) ? 10 : v + 1);
        ny = y + nv;
        floor_hit = 1'b0;
        if (ny <= 0) begin
            y = 0;
            v = 0;
        end else if (ny >= 440) begin
            y = 440;
            v = 0;
            floor_hit = 1'b1;
        end else begin
            y = ny;
            v = nv;
        end
    endtask

    // One frame with or without a fresh press, checked against the model.
    task automatic frame(input string n, input bit fl);
        step(fl, 1'b1, 1'b0);
        model_tick(my, mv, fl, mfloor);
        if (mfloor) dcnt_exp++;
        expect_out(n, my, mv, mfloor ? 2 : 1, mfloor ? 1 : 0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    int hy[5] = '{232, 225, 219, 214, 210};
    int hv[5] = '{-8, -7, -6, -5, -4};

    initial begin
        reset                = 1'b0;
        bif.spacebar_pressed = 1'b0;
        bif.frame_tick       = 1'b0;
        bif.game_over        = 1'b0;
        #1 reset = 1'b1;
        expect_out("reset", 240, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle in WAIT: ticks must not move anything.
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 1'b0);
            expect_out("wait_idle", 240, 0, 0, 0);
        end

        // Press and hold; only one flap despite the held key.
        step(1'b1, 1'b0, 1'b0);
        expect_out("press_to_fly", 240, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            expect_out("held_key", hy[i], hv[i], 1, 0);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end

        // Free fall to the floor; velocity saturates along the way.
        my = 210;
        mv = -4;
        mfloor = 1'b0;
        for (int i = 0; i < 200 && !mfloor; i++) frame("fall", 1'b0);
        expect_out("dead_after_floor", 440, 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            expect_out("dead_frozen", 440, 0, 2, 0);
        end

        // Restart to WAIT.
        step(1'b1, 1'b0, 1'b0);
        expect_out("restart", 240, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0);

        // Press and tick on the same edge in WAIT, then keep flapping up.
        my = 240;
        mv = 0;
        frame("flap_same_edge", 1'b1);
        for (int i = 0; i < 25; i++) frame("flap_up", 1'b1);
        for (int i = 0; i < 7; i++) frame("coast_up", 1'b0);
        expect_out("at_y4", 4, -1, 1, 0);
        step(1'b1, 1'b1, 1'b0);
        expect_out("ceil_clamp", 0, 0, 1, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("after_ceil", 1, 1, 1, 0);
        step(1'b0, 1'b0, 1'b0);
        my = 1;
        mv = 1;

        // Fall to about Y=300, then collide on the same edge as a tick.
        for (int i = 0; i < 100 && my < 300; i++) frame("fall_to_300", 1'b0);
        step(1'b0, 1'b1, 1'b1);
        dcnt_exp++;
        expect_out("go_with_tick", my, mv, 2, 1);
        step(1'b0, 1'b0, 1'b1);
        expect_out("go_pulse_end", my, mv, 2, 0);
        step(1'b0, 1'b1, 1'b1);
        expect_out("go_frozen", my, mv, 2, 0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("press_ignored", my, mv, 2, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("restart_go", 240, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame while flying.
        step(1'b1, 1'b0, 1'b0);
        expect_out("fly_again", 240, 0, 1, 0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("pend_flap", 232, -8, 1, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        expect_out("async_reset", 240, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        expect_out("post_reset", 240, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending checks, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
